// File: rtl/pic_bus_pkg.sv
// Shared types and constants for the 8259A bus master.
// Holds the sequencer states, bus-cycle phases, ICW1 bit positions and A0 levels.
// No logic lives here apart from the ICW successor helper.
package pic_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ICW1, ST_ICW2, ST_ICW3, ST_ICW4, ST_READY, ST_CMD
  } state_e;

  typedef enum logic [2:0] {
    PH_IDLE, PH_SETUP, PH_STROBE, PH_HOLD, PH_RECOVER
  } phase_e;

  localparam int IC4     = 0;
  localparam int SNGL    = 1;
  localparam int ICW1_ID = 4;

  localparam logic A0_LO = 1'b0;
  localparam logic A0_HI = 1'b1;

  // ICW3 only exists in cascade mode, ICW4 only when IC4 asks for it.
  function automatic state_e next_icw(input state_e cur, input logic [7:0] i1);
    state_e nxt;
    nxt = ST_READY;
    case (cur)
      ST_ICW1: nxt = ST_ICW2;
      ST_ICW2: nxt = !i1[SNGL] ? ST_ICW3 : (i1[IC4] ? ST_ICW4 : ST_READY);
      ST_ICW3: nxt = i1[IC4] ? ST_ICW4 : ST_READY;
      default: nxt = ST_READY;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/pic_bus_cycle.sv
// One 8259A bus cycle: SETUP, STROBE x STROBE_CYCLES, HOLD, RECOVER x RECOVERY_CYCLES.
// Latency: 2+STROBE_CYCLES+RECOVERY_CYCLES clocks from start to the done clock.
// start is taken only when idle or on the done clock (back-to-back); strobes decode from flops.
module pic_bus_cycle
  import pic_bus_pkg::*;
#(
  parameter int STROBE_CYCLES   = 2,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       read,
  input  logic       a0,
  input  logic [7:0] wdata,
  input  logic [7:0] D_in,
  output logic       done,
  output logic       CS_n,
  output logic       WR_n,
  output logic       RD_n,
  output logic       A0,
  output logic [7:0] D_out,
  output logic       D_oe,
  output logic [7:0] rd_data,
  output logic       rd_valid
);

  localparam logic [3:0] STB_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] REC_LAST = 4'(RECOVERY_CYCLES - 1);

  phase_e     phase_q, phase_d;
  logic [3:0] cnt_q, cnt_d;
  logic       read_q, read_d;
  logic       a0_q, a0_d;
  logic [7:0] dout_q, dout_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;
  logic       active;

  // Phase sequencing, read capture and command latching.
  always_comb begin
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    read_d     = read_q;
    a0_d       = a0_q;
    dout_d     = dout_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done       = (phase_q == PH_RECOVER) && (cnt_q == REC_LAST);
    case (phase_q)
      PH_SETUP: begin
        phase_d = PH_STROBE;
        cnt_d   = 4'd0;
      end
      PH_STROBE: begin
        if (cnt_q == STB_LAST) begin
          phase_d = PH_HOLD;
          if (read_q) begin
            rd_data_d  = D_in;
            rd_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      PH_HOLD: begin
        phase_d = PH_RECOVER;
        cnt_d   = 4'd0;
      end
      PH_RECOVER: begin
        if (done) phase_d = PH_IDLE;
        else      cnt_d   = cnt_q + 4'd1;
      end
      default: phase_d = PH_IDLE;
    endcase
    if (start && (phase_q == PH_IDLE || done)) begin
      phase_d = PH_SETUP;
      read_d  = read;
      a0_d    = a0;
      dout_d  = wdata;
    end
  end

  // State register; reset drops every strobe at once through the decode below.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q    <= PH_IDLE;
      cnt_q      <= 4'd0;
      read_q     <= 1'b0;
      a0_q       <= 1'b0;
      dout_q     <= 8'h00;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      read_q     <= read_d;
      a0_q       <= a0_d;
      dout_q     <= dout_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Bus pin decode from the phase register.
  always_comb begin
    active   = (phase_q == PH_SETUP) || (phase_q == PH_STROBE) || (phase_q == PH_HOLD);
    CS_n     = !active;
    WR_n     = !((phase_q == PH_STROBE) && !read_q);
    RD_n     = !((phase_q == PH_STROBE) && read_q);
    D_oe     = active && !read_q;
    A0       = a0_q;
    D_out    = dout_q;
    rd_data  = rd_data_q;
    rd_valid = rd_valid_q;
  end

endmodule

// File: rtl/pic_bus_master.sv
// 8259A initialisation sequencer and host command port on top of pic_bus_cycle.
// Latency: a command returns to cmd_ready 2+STROBE_CYCLES+RECOVERY_CYCLES clocks after acceptance.
// cmd_ready only in READY without start_init; start_init is ignored during ICW writes and commands.
module pic_bus_master
  import pic_bus_pkg::*;
#(
  parameter int STROBE_CYCLES   = 2,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_init,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_read,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_wdata,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       init_done,
  output logic       busy,
  output logic       CS_n,
  output logic       WR_n,
  output logic       RD_n,
  output logic       A0,
  output logic [7:0] D_out,
  output logic       D_oe,
  input  logic [7:0] D_in
);

  state_e     state_q, state_d;
  logic       init_done_q, init_done_d;
  logic [7:0] icw1_q, icw1_d, icw2_q, icw2_d, icw3_q, icw3_d, icw4_q, icw4_d;
  logic       bus_start, bus_read, bus_a0, bus_done;
  logic [7:0] bus_wdata;

  // Next state and bus-cycle launch; launches coincide with the transition so cycles chain gaplessly.
  always_comb begin
    state_d     = state_q;
    init_done_d = init_done_q;
    icw1_d      = icw1_q;
    icw2_d      = icw2_q;
    icw3_d      = icw3_q;
    icw4_d      = icw4_q;
    bus_start   = 1'b0;
    bus_read    = 1'b0;
    bus_a0      = A0_LO;
    bus_wdata   = 8'h00;
    case (state_q)
      ST_ICW1, ST_ICW2, ST_ICW3, ST_ICW4: begin
        if (bus_done) begin
          state_d = next_icw(state_q, icw1_q);
          case (state_d)
            ST_ICW2: begin bus_start = 1'b1; bus_a0 = A0_HI; bus_wdata = icw2_q; end
            ST_ICW3: begin bus_start = 1'b1; bus_a0 = A0_HI; bus_wdata = icw3_q; end
            ST_ICW4: begin bus_start = 1'b1; bus_a0 = A0_HI; bus_wdata = icw4_q; end
            default: init_done_d = 1'b1;
          endcase
        end
      end
      ST_CMD: begin
        if (bus_done) state_d = ST_READY;
      end
      default: begin
        if (start_init) begin
          state_d              = ST_ICW1;
          init_done_d          = 1'b0;
          icw1_d               = icw1;
          icw2_d               = icw2;
          icw3_d               = icw3;
          icw4_d               = icw4;
          bus_start            = 1'b1;
          bus_a0               = A0_LO;
          bus_wdata            = icw1;
          bus_wdata[ICW1_ID]   = 1'b1;
        end else if (state_q == ST_READY && cmd_valid) begin
          state_d   = ST_CMD;
          bus_start = 1'b1;
          bus_read  = cmd_read;
          bus_a0    = cmd_a0;
          bus_wdata = cmd_wdata;
        end
      end
    endcase
  end

  // Sequencer state and captured configuration bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      init_done_q <= 1'b0;
      icw1_q      <= 8'h00;
      icw2_q      <= 8'h00;
      icw3_q      <= 8'h00;
      icw4_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_d;
      icw1_q      <= icw1_d;
      icw2_q      <= icw2_d;
      icw3_q      <= icw3_d;
      icw4_q      <= icw4_d;
    end
  end

  // Host-side status.
  always_comb begin
    cmd_ready = (state_q == ST_READY) && !start_init;
    busy      = (state_q != ST_IDLE) && (state_q != ST_READY);
    init_done = init_done_q;
  end

  pic_bus_cycle #(
    .STROBE_CYCLES  (STROBE_CYCLES),
    .RECOVERY_CYCLES(RECOVERY_CYCLES)
  ) u_cycle (
    .clk     (clk),
    .reset   (reset),
    .start   (bus_start),
    .read    (bus_read),
    .a0      (bus_a0),
    .wdata   (bus_wdata),
    .D_in    (D_in),
    .done    (bus_done),
    .CS_n    (CS_n),
    .WR_n    (WR_n),
    .RD_n    (RD_n),
    .A0      (A0),
    .D_out   (D_out),
    .D_oe    (D_oe),
    .rd_data (rd_data),
    .rd_valid(rd_valid)
  );

endmodule

// File: tb/tb_pic_bus_master.sv
// Directed bench for pic_bus_master with STROBE_CYCLES=2, RECOVERY_CYCLES=1.
// Logs every write strobe as {A0, D_out} and checks sequences, timing and reset behaviour.
// Inputs change 1 ns after the rising edge; outputs are sampled there or at the falling edge.
module tb_pic_bus_master;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_init = 1'b0;
  logic [7:0] icw1 = 8'h00, icw2 = 8'h00, icw3 = 8'h00, icw4 = 8'h00;
  logic       cmd_valid = 1'b0, cmd_read = 1'b0, cmd_a0 = 1'b0;
  logic [7:0] cmd_wdata = 8'h00;
  logic [7:0] D_in = 8'h00;
  logic       cmd_ready, rd_valid, init_done, busy;
  logic [7:0] rd_data, D_out;
  logic       CS_n, WR_n, RD_n, A0, D_oe;

  int checks = 0;
  int failures = 0;

  logic [8:0] wr_log[$];
  logic       wr_prev = 1'b1;

  pic_bus_master #(.STROBE_CYCLES(2), .RECOVERY_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .start_init(start_init),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
    .cmd_a0(cmd_a0), .cmd_wdata(cmd_wdata),
    .rd_data(rd_data), .rd_valid(rd_valid), .init_done(init_done), .busy(busy),
    .CS_n(CS_n), .WR_n(WR_n), .RD_n(RD_n), .A0(A0),
    .D_out(D_out), .D_oe(D_oe), .D_in(D_in)
  );

  always #5 clk = ~clk;

  // Write-strobe logger: one entry per falling edge of WR_n.
  always @(negedge clk) begin
    if (wr_prev && !WR_n) wr_log.push_back({A0, D_out});
    wr_prev = WR_n;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse start_init and return the clocks until init_done rises.
  task automatic run_init(input logic [7:0] i1, i2, i3, i4, output int clks);
    icw1 = i1; icw2 = i2; icw3 = i3; icw4 = i4;
    @(posedge clk); #1 start_init = 1'b1;
    @(posedge clk); #1 start_init = 1'b0;
    clks = 0;
    while (!init_done && clks < 200) begin
      @(posedge clk); #1 clks++;
    end
  endtask

  // Issue one command and profile the bus cycle it produces.
  task automatic run_cmd(input logic rd, input logic a, input logic [7:0] wd,
                         output int lat, output int doe, output int wrl,
                         output int rdl, output int rvl, output int a0hi);
    @(posedge clk); #1;
    check("cmd_ready_before", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_read = rd; cmd_a0 = a; cmd_wdata = wd;
    @(posedge clk); #1 cmd_valid = 1'b0;
    lat = 0; doe = 0; wrl = 0; rdl = 0; rvl = 0; a0hi = 0;
    while (!cmd_ready && lat < 50) begin
      if (D_oe) doe++;
      if (!WR_n) wrl++;
      if (!RD_n) rdl++;
      if (rd_valid) rvl++;
      if (!CS_n && A0) a0hi++;
      @(posedge clk); #1 lat++;
    end
  endtask

  initial begin
    int n, base, lat, doe, wrl, rdl, rvl, a0hi;

    // Reset state.
    #12;
    check("rst_cs_n", CS_n, 1);
    check("rst_wr_n", WR_n, 1);
    check("rst_rd_n", RD_n, 1);
    check("rst_a0", A0, 0);
    check("rst_d_oe", D_oe, 0);
    check("rst_d_out", D_out, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_init_done", init_done, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Single-chip with ICW4: three writes, 15 clocks.
    base = wr_log.size();
    run_init(8'h13, 8'h20, 8'h04, 8'h01, n);
    check("init13_clks", n, 15);
    check("init13_nwr", wr_log.size() - base, 3);
    if (wr_log.size() - base == 3) begin
      check("init13_w0", wr_log[base],   {1'b0, 8'h13});
      check("init13_w1", wr_log[base+1], {1'b1, 8'h20});
      check("init13_w2", wr_log[base+2], {1'b1, 8'h01});
    end
    check("init13_ready", cmd_ready, 1);
    check("init13_busy", busy, 0);

    // Cascade with ICW4: four writes, ID bit forced.
    base = wr_log.size();
    run_init(8'h01, 8'h40, 8'h02, 8'h03, n);
    check("init01_clks", n, 20);
    check("init01_nwr", wr_log.size() - base, 4);
    if (wr_log.size() - base == 4) begin
      check("init01_w0", wr_log[base],   {1'b0, 8'h11});
      check("init01_w1", wr_log[base+1], {1'b1, 8'h40});
      check("init01_w2", wr_log[base+2], {1'b1, 8'h02});
      check("init01_w3", wr_log[base+3], {1'b1, 8'h03});
    end

    // Single-chip without ICW4: two writes.
    base = wr_log.size();
    run_init(8'h02, 8'h60, 8'h77, 8'h88, n);
    check("init02_clks", n, 10);
    check("init02_nwr", wr_log.size() - base, 2);
    if (wr_log.size() - base == 2) begin
      check("init02_w0", wr_log[base],   {1'b0, 8'h12});
      check("init02_w1", wr_log[base+1], {1'b1, 8'h60});
    end

    // OCW write with A0=0 and bit 4 set goes out untouched.
    base = wr_log.size();
    run_cmd(1'b0, 1'b0, 8'h1B, lat, doe, wrl, rdl, rvl, a0hi);
    check("wr_latency", lat, 5);
    check("wr_doe_clks", doe, 4);
    check("wr_strobe_clks", wrl, 2);
    check("wr_rd_clks", rdl, 0);
    check("wr_nwr", wr_log.size() - base, 1);
    if (wr_log.size() - base == 1) check("wr_byte", wr_log[base], {1'b0, 8'h1B});

    // Read with A0=1.
    D_in = 8'hA5;
    run_cmd(1'b1, 1'b1, 8'h00, lat, doe, wrl, rdl, rvl, a0hi);
    check("rd_latency", lat, 5);
    check("rd_strobe_clks", rdl, 2);
    check("rd_doe_clks", doe, 0);
    check("rd_wr_clks", wrl, 0);
    check("rd_valid_pulses", rvl, 1);
    check("rd_a0_clks", a0hi, 4);
    check("rd_data", rd_data, 8'hA5);
    D_in = 8'h00;

    // start_init beats a simultaneous command.
    base = wr_log.size();
    icw1 = 8'h13; icw2 = 8'h20; icw3 = 8'h00; icw4 = 8'h01;
    @(posedge clk); #1;
    start_init = 1'b1; cmd_valid = 1'b1; cmd_read = 1'b1; cmd_a0 = 1'b1;
    #1 check("coll_cmd_ready", cmd_ready, 0);
    @(posedge clk); #1 start_init = 1'b0; cmd_valid = 1'b0;
    check("coll_busy", busy, 1);
    check("coll_init_done_clr", init_done, 0);
    check("coll_setup_doe", D_oe, 1);
    check("coll_setup_a0", A0, 0);
    n = 0; rdl = 0;
    while (!init_done && n < 200) begin
      if (!RD_n) rdl++;
      @(posedge clk); #1 n++;
    end
    check("coll_clks", n, 15);
    check("coll_no_read", rdl, 0);
    check("coll_nwr", wr_log.size() - base, 3);
    if (wr_log.size() - base == 3) check("coll_w0", wr_log[base], {1'b0, 8'h13});

    // Reset in the middle of the ICW2 strobe.
    base = wr_log.size();
    @(posedge clk); #1 start_init = 1'b1;
    @(posedge clk); #1 start_init = 1'b0;
    n = 0;
    while (wr_log.size() < base + 2 && n < 100) begin
      @(negedge clk); #1 n++;
    end
    check("mid_reached_icw2", wr_log.size() - base, 2);
    check("mid_wr_low", WR_n, 0);
    reset = 1'b1;
    #1;
    check("mid_rst_wr_n", WR_n, 1);
    check("mid_rst_cs_n", CS_n, 1);
    check("mid_rst_d_oe", D_oe, 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_init_done", init_done, 0);
    check("post_rst_cmd_ready", cmd_ready, 0);
    check("post_rst_cs_n", CS_n, 1);
    check("post_rst_nwr", wr_log.size() - base, 2);
    base = wr_log.size();
    run_init(8'h13, 8'h20, 8'h00, 8'h01, n);
    check("reinit_clks", n, 15);
    check("reinit_nwr", wr_log.size() - base, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
